// File: rtl/range_bit_expander_pkg.sv
// Shared types and default widths for the range-to-bit expander.
package range_pkg;
  localparam int unsigned IDX_W_DEF = 32;
  localparam int unsigned POS_W_DEF = 16;

  typedef logic signed [IDX_W_DEF-1:0] idx_t;
  typedef logic        [POS_W_DEF-1:0] pos_t;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;
endpackage

// File: rtl/range_bit_expander_if.sv
// Descriptor input stream and flattened bit-index output stream.
interface range_bit_expander_if
  import range_pkg::*;
#(
  parameter int unsigned IDX_W = IDX_W_DEF,
  parameter int unsigned POS_W = POS_W_DEF
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IDX_W-1:0] in_msb;
  logic signed [IDX_W-1:0] in_lsb;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [IDX_W-1:0] out_idx;
  logic                    out_elem_first;
  logic                    out_last;
  logic        [POS_W-1:0] out_pos;

  modport master (
    output in_valid, in_msb, in_lsb, in_last, out_ready,
    input  in_ready, out_valid, out_idx, out_elem_first, out_last, out_pos
  );

  modport slave (
    input  in_valid, in_msb, in_lsb, in_last, out_ready,
    output in_ready, out_valid, out_idx, out_elem_first, out_last, out_pos
  );
endinterface

// File: rtl/range_bit_expander_walker.sv
// Walks one element's bit indices from msb toward lsb in either direction.
module range_walker
  import range_pkg::*;
#(
  parameter int unsigned IDX_W = IDX_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic                    adv,
  input  logic signed [IDX_W-1:0] ld_msb,
  input  logic signed [IDX_W-1:0] ld_lsb,
  output logic signed [IDX_W-1:0] cur,
  output logic                    at_end_c,
  output logic                    nxt_at_end_c
);
  logic signed [IDX_W-1:0] fin;
  logic signed [IDX_W-1:0] nxt;
  logic                    down;

  // Stepping stops on equality, so the index never wraps past the bound.
  assign nxt          = down ? cur - IDX_W'(1) : cur + IDX_W'(1);
  assign at_end_c     = (cur == fin);
  assign nxt_at_end_c = (nxt == fin);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur  <= '0;
      fin  <= '0;
      down <= 1'b0;
    end else if (load) begin
      cur  <= ld_msb;
      fin  <= ld_lsb;
      down <= (ld_msb >= ld_lsb);
    end else if (adv) begin
      cur  <= nxt;
    end
  end
endmodule

// File: rtl/range_bit_expander.sv
// Expands a stream of {msb,lsb} range descriptors into one bit index per cycle.
module range_bit_expander
  import range_pkg::*;
#(
  parameter int unsigned IDX_W = IDX_W_DEF,
  parameter int unsigned POS_W = POS_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  range_bit_expander_if.slave  bus,
  output logic                 pos_ovf
);
  state_e                  state;
  logic                    ready_en;
  logic                    lastel;
  logic                    at_end_c;
  logic                    nxt_at_end_c;
  logic                    xfer_c;
  logic                    accept_c;
  logic                    adv_c;
  logic signed [IDX_W-1:0] cur;

  // Taking the next descriptor as the current element's final bit leaves keeps 1 bit/cycle.
  assign bus.in_ready = ready_en &
                        ((state == IDLE) | ((state == EMIT) & at_end_c & bus.out_ready));
  assign xfer_c       = bus.out_valid & bus.out_ready;
  assign accept_c     = bus.in_valid & bus.in_ready;
  assign adv_c        = xfer_c & ~at_end_c;
  assign bus.out_idx  = cur;

  range_walker #(.IDX_W(IDX_W)) u_walker (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (accept_c),
    .adv          (adv_c),
    .ld_msb       (bus.in_msb),
    .ld_lsb       (bus.in_lsb),
    .cur          (cur),
    .at_end_c     (at_end_c),
    .nxt_at_end_c (nxt_at_end_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      ready_en           <= 1'b0;
      lastel             <= 1'b0;
      bus.out_valid      <= 1'b0;
      bus.out_elem_first <= 1'b0;
      bus.out_last       <= 1'b0;
      bus.out_pos        <= '0;
      pos_ovf            <= 1'b0;
    end else begin
      ready_en <= 1'b1;

      if (accept_c) begin
        state              <= EMIT;
        lastel             <= bus.in_last;
        bus.out_valid      <= 1'b1;
        bus.out_elem_first <= 1'b1;
        bus.out_last       <= bus.in_last & (bus.in_msb == bus.in_lsb);
      end else if ((state == EMIT) && xfer_c) begin
        if (at_end_c) begin
          state              <= IDLE;
          bus.out_valid      <= 1'b0;
          bus.out_elem_first <= 1'b0;
          bus.out_last       <= 1'b0;
        end else begin
          bus.out_elem_first <= 1'b0;
          bus.out_last       <= lastel & nxt_at_end_c;
        end
      end

      // Position restarts after the connection's final bit; wrapping earlier is an overflow.
      if (xfer_c) begin
        if (bus.out_last) begin
          bus.out_pos <= '0;
        end else begin
          bus.out_pos <= bus.out_pos + POS_W'(1);
          if (&bus.out_pos) pos_ovf <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_range_bit_expander.sv
// Scoreboard bench for range_bit_expander: queued expectations from a range model.
module tb_range_bit_expander;
  localparam int unsigned IDX_W = 32;
  localparam int unsigned POS_W = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ovf;
  logic ovf2;

  always #5 clk = ~clk;

  range_bit_expander_if #(.IDX_W(IDX_W), .POS_W(POS_W)) bus ();
  range_bit_expander_if #(.IDX_W(IDX_W), .POS_W(2))     bus2 ();

  range_bit_expander #(.IDX_W(IDX_W), .POS_W(POS_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .pos_ovf(ovf)
  );

  range_bit_expander #(.IDX_W(IDX_W), .POS_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .pos_ovf(ovf2)
  );

  typedef struct {
    longint idx;
    bit     first;
    bit     last;
    longint pos;
  } exp_t;

  exp_t   q[$];
  longint xcyc[$];
  exp_t   mon_e;
  int     n_cmp  = 0;
  int     n_err  = 0;
  int     n_xfer = 0;
  longint cyc    = 0;
  longint mpos   = 0;
  bit     rnd_rdy = 1'b0;
  bit     prev_stall = 1'b0;
  longint snap_idx;
  longint snap_pos;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: an element is |msb-lsb|+1 indices walked from msb toward lsb.
  task automatic push_desc(input longint msb, input longint lsb, input bit last);
    longint w;
    exp_t   e;
    w = (msb >= lsb) ? (msb - lsb + 1) : (lsb - msb + 1);
    for (longint i = 0; i < w; i++) begin
      e.idx   = (msb >= lsb) ? (msb - i) : (msb + i);
      e.first = (i == 0);
      e.last  = last && (i == w - 1);
      e.pos   = mpos;
      q.push_back(e);
      mpos = e.last ? 0 : (mpos + 1) % 65536;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input longint msb, input longint lsb, input bit last);
    bit acc;
    push_desc(msb, lsb, last);
    bus.in_valid = 1'b1;
    bus.in_msb   = IDX_W'(msb);
    bus.in_lsb   = IDX_W'(lsb);
    bus.in_last  = last;
    acc = 1'b0;
    for (int k = 0; k < 2000 && !acc; k++) begin
      @(negedge clk);
      acc = bus.in_ready;
      tick();
    end
    if (!acc) chk("accept_timeout", 0, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 5000; k++) begin
      if (q.size() == 0 && !bus.out_valid) break;
      tick();
    end
    chk("drain_left", q.size(), 0);
  endtask

  // Monitor: each transfer pops one expected bit; stalls must hold the output steady.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_idx", bus.out_idx, snap_idx);
        chk("hold_pos", bus.out_pos, snap_pos);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_bit: got idx %0d expected none", bus.out_idx);
        end else begin
          mon_e = q.pop_front();
          chk("idx",        bus.out_idx,        mon_e.idx);
          chk("elem_first", bus.out_elem_first, longint'(mon_e.first));
          chk("last",       bus.out_last,       longint'(mon_e.last));
          chk("pos",        bus.out_pos,        mon_e.pos);
        end
        xcyc.push_back(cyc);
        n_xfer++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      snap_idx   = bus.out_idx;
      snap_pos   = bus.out_pos;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int     base;
    longint ex;
    bit     seq[6];
    int     ne;
    longint msb;
    longint lsb;

    bus.in_valid  = 1'b0; bus.in_msb  = '0; bus.in_lsb  = '0; bus.in_last  = 1'b0;
    bus.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_msb = '0; bus2.in_lsb = '0; bus2.in_last = 1'b0;
    bus2.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",   bus.in_ready,       0);
    chk("rst_out_valid",  bus.out_valid,      0);
    chk("rst_out_idx",    bus.out_idx,        0);
    chk("rst_elem_first", bus.out_elem_first, 0);
    chk("rst_out_last",   bus.out_last,       0);
    chk("rst_out_pos",    bus.out_pos,        0);
    chk("rst_pos_ovf",    ovf,                0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Ascending range, then latency of the first bit.
    bus.out_ready = 1'b1;
    send(3, 6, 1'b1);
    @(negedge clk);
    chk("latency_valid", bus.out_valid, 1);
    wait_idle();

    // Signed bounds and a full 32-bit descending range.
    send(-2, 1, 1'b1);
    send(31, 0, 1'b1);
    wait_idle();

    // Single-bit concat elements offered back to back.
    base = xcyc.size();
    send(0, 0, 1'b0);
    send(7, 7, 1'b0);
    send(2, 2, 1'b0);
    send(-2, -2, 1'b1);
    wait_idle();
    for (int k = 1; k < 4; k++) chk("concat_gap", xcyc[base+k] - xcyc[base+k-1], 1);

    // Scripted backpressure on a descending element.
    seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    bus.out_ready = 1'b1;
    send(3, 0, 1'b1);
    ex = 3;
    for (int k = 0; k < 6; k++) begin
      bus.out_ready = seq[k];
      @(negedge clk);
      chk("bp_in_ready", bus.in_ready, longint'(ex == 0 && seq[k]));
      chk("bp_idx", bus.out_idx, ex);
      if (seq[k]) ex--;
      tick();
    end
    bus.out_ready = 1'b1;
    wait_idle();

    // Reset in the middle of an element discards it.
    base = n_xfer;
    send(15, 0, 1'b1);
    for (int k = 0; k < 100 && n_xfer < base + 4; k++) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready",   bus.in_ready,       0);
    chk("mid_rst_out_valid",  bus.out_valid,      0);
    chk("mid_rst_out_idx",    bus.out_idx,        0);
    chk("mid_rst_elem_first", bus.out_elem_first, 0);
    chk("mid_rst_out_last",   bus.out_last,       0);
    chk("mid_rst_out_pos",    bus.out_pos,        0);
    q.delete();
    mpos = 0;
    tick();
    rst_n = 1'b1;
    send(1, 0, 1'b1);
    wait_idle();
    chk("main_pos_ovf", ovf, 0);

    // Narrow position counter: 5-bit connection wraps and sets the sticky flag.
    tick();
    bus2.in_valid = 1'b1;
    bus2.in_msb   = IDX_W'(0);
    bus2.in_lsb   = IDX_W'(4);
    bus2.in_last  = 1'b1;
    @(negedge clk);
    chk("ovf_in_ready", bus2.in_ready, 1);
    tick();
    bus2.in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("ovf_valid", bus2.out_valid, 1);
      chk("ovf_idx",   bus2.out_idx,   k);
      chk("ovf_pos",   bus2.out_pos,   k % 4);
      chk("ovf_last",  bus2.out_last,  longint'(k == 4));
      chk("ovf_flag",  ovf2,           longint'(k == 4));
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("ovf_sticky", ovf2, 1);
      chk("ovf_idle",   bus2.out_valid, 0);
      tick();
    end

    // Randomized connections under random backpressure.
    rnd_rdy = 1'b1;
    for (int c = 0; c < 40; c++) begin
      ne = int'($urandom_range(1, 4));
      for (int e = 0; e < ne; e++) begin
        msb = longint'($urandom_range(0, 16)) - 8;
        lsb = longint'($urandom_range(0, 16)) - 8;
        send(msb, lsb, e == ne - 1);
      end
      if ($urandom_range(0, 3) == 0) tick();
    end
    wait_idle();
    rnd_rdy = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
